// File: rtl/fib_seq_gen_pkg.sv
// Shared FSM encodings and the active-low hex glyph table for the Fibonacci generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fib_seq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/fib_seq_gen_hex_to_seg7.sv
// One hex nibble to an active-low 7-segment glyph.
// Latency: combinational.
// Backpressure: none.
module hex_to_seg7
    import fib_seq_gen_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci term generator: steps on a debounced switch edge or a prescaled auto-run tick.
// Latency: step pin edge sampled at clk edge k shows on value at edge k+2; seg is combinational.
// Backpressure: none; overflow either halts on the last term or wraps to F0.
module fib_seq_gen
    import fib_seq_gen_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int IDX_W    = 8,
    parameter int PRESCALE = 50000000,
    localparam int DIGITS  = WIDTH / 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  run,
    input  logic                  mode_wrap,
    input  logic                  restart,
    input  logic                  ovf_clr,
    output logic [WIDTH-1:0]      value,
    output logic [IDX_W-1:0]      index,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  ovf
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [IDX_W-1:0]  idx_q;
    logic [PW-1:0]     presc;
    logic              ovf_q;
    logic              step_s1, step_s2, step_s3;
    logic              run_s1, run_s2;

    logic              step_edge;
    logic              presc_last;
    logic              adv;
    logic [WIDTH:0]    sum;
    logic              carry;

    assign step_edge  = step_s2 & ~step_s3;
    assign presc_last = (presc == PW'(PRESCALE - 1));
    assign adv        = ((state == ST_IDLE) && step_edge) ||
                        ((state == ST_RUN) && run_s2 && presc_last);
    assign sum        = {1'b0, a_q} + {1'b0, b_q};
    assign carry      = sum[WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
            step_s3 <= 1'b0;
            run_s1  <= 1'b0;
            run_s2  <= 1'b0;
        end else begin
            step_s1 <= step;
            step_s2 <= step_s1;
            step_s3 <= step_s2;
            run_s1  <= run;
            run_s2  <= run_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            a_q   <= WIDTH'(1);
            b_q   <= '0;
            idx_q <= '0;
            presc <= '0;
            ovf_q <= 1'b0;
        end else if (restart) begin
            state <= ST_IDLE;
            a_q   <= WIDTH'(1);
            b_q   <= '0;
            idx_q <= '0;
            presc <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (ovf_clr)
                ovf_q <= 1'b0;

            case (state)
                ST_IDLE: if (run_s2) state <= ST_RUN;
                ST_RUN: begin
                    if (!run_s2) begin
                        state <= ST_IDLE;
                        presc <= '0;
                    end else if (presc_last) begin
                        presc <= '0;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: state <= ST_HALT;
            endcase

            // Placed after the FSM case so a halting overflow overrides IDLE->RUN
            if (adv) begin
                if (carry) begin
                    ovf_q <= 1'b1;
                    if (mode_wrap) begin
                        a_q   <= WIDTH'(1);
                        b_q   <= '0;
                        idx_q <= '0;
                    end else begin
                        state <= ST_HALT;
                    end
                end else begin
                    a_q   <= b_q;
                    b_q   <= sum[WIDTH-1:0];
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign value = b_q;
    assign index = idx_q;
    assign ovf   = ovf_q;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        hex_to_seg7 u_seg (
            .nib (b_q[4*k+3:4*k]),
            .seg (seg[7*k+6:7*k])
        );
    end

endmodule
